insn_encoder: RTL and testbench
===============================

// Module: insn_encoder
// PURPOSE
//  Encodes decoded RV32I operation descriptors (opcode, ALU select, funct3, regs, immediate) into 32-bit instruction words.
//  It is the inverse of the decode/control path and feeds self-checking program generators and the imem loader.
//  Valid/ready on both sides, with a 2-entry in-order output buffer.
//  Illegal descriptors emit a flagged NOP.
// PARAMETERS
//  DWIDTH     32  instruction/immediate width (RV32I only; fixed at 32)
//  ERRCNT_W   16  width of saturating error counter
// PORTS
//  clk            in   1         clock
//  reset          in   1         synchronous, active-high reset
//  cmd_valid_i    in   1         descriptor valid
//  cmd_ready_o    out  1         encoder can accept descriptor
//  cmd_opcode_i   in   7         RTYPE/ITYPE/LOAD/STORE/BRANCH/JAL/JALR/LUI/AUIPC (constants.svh)
//  cmd_alusel_i   in   4         ALU select (constants.svh), used for RTYPE/ITYPE only
//  cmd_funct3_i   in   3         funct3 for LOAD/STORE/BRANCH only
//  cmd_rd_i       in   5         destination reg
//  cmd_rs1_i      in   5         source reg 1
//  cmd_rs2_i      in   5         source reg 2
//  cmd_imm_i      in   DWIDTH    full-value immediate/offset (byte offset for B/J; full upper value for LUI/AUIPC)
//  insn_valid_o   out  1         encoded word valid
//  insn_ready_i   in   1         consumer accepts word
//  insn_o         out  DWIDTH    encoded instruction
//  err_o          out  1         word is replacement NOP for an illegal descriptor
//  insn_count_o   out  32        words delivered (wraps)
//  err_count_o    out  ERRCNT_W  illegal descriptors delivered (saturates at all-ones)
// BEHAVIOUR
//  Reset values:
//  - insn_valid_o=0, insn_o=0, err_o=0, both counters 0, buffer state EMPTY.
//  - cmd_ready_o=0 while reset is high; input is ignored.
//  Buffer FSM (states EMPTY/ONE/TWO):
//  - Push when cmd_valid_i&cmd_ready_o; pop when insn_valid_o&insn_ready_i.
//  - cmd_ready_o=(state!=TWO)&~reset. insn_valid_o=(state!=EMPTY).
//  - Transitions: EMPTY->ONE on push; ONE->TWO on push without pop; ONE->EMPTY on pop without push; TWO->ONE on pop.
//  - ONE with push+pop stays ONE: the head leaves and the new word becomes head.
//  - Latency: accepted in cycle N -> insn_valid_o in N+1 when EMPTY. Strict FIFO order; no drops.
//  - insn_o/err_o hold stable while insn_valid_o&~insn_ready_i.
//  Encoding (standard RV32I fields):
//  - R: funct7=7'h20 for SUB/SRA, else 0. Legal alusel: ADD SUB XOR OR AND SLL SRL SRA SLT SLTU.
//  - I: imm[11:0]. SLLI/SRLI -> insn[31:25]=0; SRAI -> 7'h20; shamt=imm[4:0]. SUB illegal.
//  - LOAD funct3 in {0,1,2,4,5}; STORE in {0,1,2}; BRANCH in {0,1,4,5,6,7}. JALR funct3=0.
//  - U: insn[31:12]=imm[31:12]. J/B: scrambled per ISA from imm[20:1]/imm[12:1].
//  - Unused fields are emitted 0: rd for S/B; rs2 for I/U/J; rs1 for U/J.
//  Legality, otherwise illegal:
//  - I/LOAD/STORE/JALR imm sign-fits 12b; shifts imm[31:5]=0.
//  - BRANCH sign-fits 13b and imm[0]=0; JAL sign-fits 21b and imm[0]=0.
//  - LUI/AUIPC imm[11:0]=0; PCADD or unknown alusel illegal; unknown opcode illegal.
//  Illegal descriptor: buffered as insn=32'h00000013, err=1, in order.
//  Counters:
//  - insn_count_o +1 on every pop; err_count_o +1 on pop with err_o=1, saturating.
//  Reset mid-operation:
//  - Buffered words are discarded, state EMPTY next cycle, counters cleared; no partial output.
// TESTING
//  R ADD rd=3 rs1=1 rs2=2 -> insn_o=0x002081B3, err_o=0, valid 1 cycle after accept.
//  R SUB rd=5 rs1=6 rs2=7 -> 0x407302B3. ITYPE ADD rd=1 rs1=0 imm=-1 -> 0xFFF00093.
//  BRANCH f3=0 rs1=1 rs2=2 imm=8 -> 0x00208463. JAL rd=1 imm=2048 -> 0x001000EF.
//  ITYPE ADD imm=2048 -> 0x00000013, err_o=1, err_count_o=1, insn_count_o=1.
//  insn_ready_i=0, offer 3 descriptors -> 2 accepted, cmd_ready_o=0; release -> all 3 out in order.
//  State TWO, reset 1 cycle -> insn_valid_o=0, counters 0, cmd_ready_o=1 after reset drops.

Source files
------------

// File: rtl/insn_encoder.sv
// ============================================================================
// Module   : insn_encoder
// Brief    : Encodes RV32I operation descriptors into 32-bit instruction words
//            behind a 2-entry in-order valid/ready output buffer.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module insn_encoder #(
    parameter int DWIDTH   = 32,
    parameter int ERRCNT_W = 16
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                cmd_valid_i,
    output logic                cmd_ready_o,
    input  logic [6:0]          cmd_opcode_i,
    input  logic [3:0]          cmd_alusel_i,
    input  logic [2:0]          cmd_funct3_i,
    input  logic [4:0]          cmd_rd_i,
    input  logic [4:0]          cmd_rs1_i,
    input  logic [4:0]          cmd_rs2_i,
    input  logic [DWIDTH-1:0]   cmd_imm_i,
    output logic                insn_valid_o,
    input  logic                insn_ready_i,
    output logic [DWIDTH-1:0]   insn_o,
    output logic                err_o,
    output logic [31:0]         insn_count_o,
    output logic [ERRCNT_W-1:0] err_count_o
);

    localparam logic [6:0] c_op_rtype  = 7'b0110011;
    localparam logic [6:0] c_op_itype  = 7'b0010011;
    localparam logic [6:0] c_op_load   = 7'b0000011;
    localparam logic [6:0] c_op_store  = 7'b0100011;
    localparam logic [6:0] c_op_branch = 7'b1100011;
    localparam logic [6:0] c_op_jal    = 7'b1101111;
    localparam logic [6:0] c_op_jalr   = 7'b1100111;
    localparam logic [6:0] c_op_lui    = 7'b0110111;
    localparam logic [6:0] c_op_auipc  = 7'b0010111;

    localparam logic [3:0] c_alu_add  = 4'd0;
    localparam logic [3:0] c_alu_sub  = 4'd1;
    localparam logic [3:0] c_alu_sll  = 4'd2;
    localparam logic [3:0] c_alu_slt  = 4'd3;
    localparam logic [3:0] c_alu_sltu = 4'd4;
    localparam logic [3:0] c_alu_xor  = 4'd5;
    localparam logic [3:0] c_alu_srl  = 4'd6;
    localparam logic [3:0] c_alu_sra  = 4'd7;
    localparam logic [3:0] c_alu_or   = 4'd8;
    localparam logic [3:0] c_alu_and  = 4'd9;

    localparam logic [31:0] c_nop = 32'h0000_0013;

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_TWO   = 2'd2
    } state_t;

    state_t                r_state;
    logic [31:0]           r_head_insn, r_tail_insn;
    logic                  r_head_err,  r_tail_err;
    logic [31:0]           r_insn_count;
    logic [ERRCNT_W-1:0]   r_err_count;

    logic                  w_alu_ok, w_alu_shift;
    logic [2:0]            w_alu_f3;
    logic [6:0]            w_alu_f7;
    logic                  w_fit12, w_fit13, w_fit21;
    logic                  w_ok;
    logic [31:0]           w_raw, w_enc;
    logic                  w_push, w_pop;

    always_comb begin
        w_alu_ok    = 1'b1;
        w_alu_shift = 1'b0;
        w_alu_f3    = 3'd0;
        w_alu_f7    = 7'h00;
        case (cmd_alusel_i)
            c_alu_add:  w_alu_f3 = 3'd0;
            c_alu_sub:  begin w_alu_f3 = 3'd0; w_alu_f7 = 7'h20; end
            c_alu_sll:  begin w_alu_f3 = 3'd1; w_alu_shift = 1'b1; end
            c_alu_slt:  w_alu_f3 = 3'd2;
            c_alu_sltu: w_alu_f3 = 3'd3;
            c_alu_xor:  w_alu_f3 = 3'd4;
            c_alu_srl:  begin w_alu_f3 = 3'd5; w_alu_shift = 1'b1; end
            c_alu_sra:  begin w_alu_f3 = 3'd5; w_alu_f7 = 7'h20; w_alu_shift = 1'b1; end
            c_alu_or:   w_alu_f3 = 3'd6;
            c_alu_and:  w_alu_f3 = 3'd7;
            default:    w_alu_ok = 1'b0;
        endcase
    end

    // An immediate sign-fits N bits when bits [31:N-1] are all equal.
    assign w_fit12 = (&cmd_imm_i[31:11]) | ~(|cmd_imm_i[31:11]);
    assign w_fit13 = (&cmd_imm_i[31:12]) | ~(|cmd_imm_i[31:12]);
    assign w_fit21 = (&cmd_imm_i[31:20]) | ~(|cmd_imm_i[31:20]);

    always_comb begin
        w_ok  = 1'b0;
        w_raw = c_nop;
        case (cmd_opcode_i)
            c_op_rtype: begin
                w_ok  = w_alu_ok;
                w_raw = {w_alu_f7, cmd_rs2_i, cmd_rs1_i, w_alu_f3, cmd_rd_i, cmd_opcode_i};
            end
            c_op_itype: begin
                if (w_alu_shift) begin
                    w_ok  = w_alu_ok && (cmd_imm_i[31:5] == 27'd0);
                    w_raw = {w_alu_f7, cmd_imm_i[4:0], cmd_rs1_i, w_alu_f3, cmd_rd_i, cmd_opcode_i};
                end else begin
                    w_ok  = w_alu_ok && (cmd_alusel_i != c_alu_sub) && w_fit12;
                    w_raw = {cmd_imm_i[11:0], cmd_rs1_i, w_alu_f3, cmd_rd_i, cmd_opcode_i};
                end
            end
            c_op_load: begin
                w_ok  = w_fit12 && (cmd_funct3_i != 3'd3) && (cmd_funct3_i[2:1] != 2'b11);
                w_raw = {cmd_imm_i[11:0], cmd_rs1_i, cmd_funct3_i, cmd_rd_i, cmd_opcode_i};
            end
            c_op_store: begin
                w_ok  = w_fit12 && (cmd_funct3_i <= 3'd2);
                w_raw = {cmd_imm_i[11:5], cmd_rs2_i, cmd_rs1_i, cmd_funct3_i,
                         cmd_imm_i[4:0], cmd_opcode_i};
            end
            c_op_branch: begin
                w_ok  = w_fit13 && !cmd_imm_i[0] && (cmd_funct3_i[2:1] != 2'b01);
                w_raw = {cmd_imm_i[12], cmd_imm_i[10:5], cmd_rs2_i, cmd_rs1_i, cmd_funct3_i,
                         cmd_imm_i[4:1], cmd_imm_i[11], cmd_opcode_i};
            end
            c_op_jal: begin
                w_ok  = w_fit21 && !cmd_imm_i[0];
                w_raw = {cmd_imm_i[20], cmd_imm_i[10:1], cmd_imm_i[11], cmd_imm_i[19:12],
                         cmd_rd_i, cmd_opcode_i};
            end
            c_op_jalr: begin
                w_ok  = w_fit12;
                w_raw = {cmd_imm_i[11:0], cmd_rs1_i, 3'd0, cmd_rd_i, cmd_opcode_i};
            end
            c_op_lui, c_op_auipc: begin
                w_ok  = (cmd_imm_i[11:0] == 12'd0);
                w_raw = {cmd_imm_i[31:12], cmd_rd_i, cmd_opcode_i};
            end
            default: w_ok = 1'b0;
        endcase
        w_enc = w_ok ? w_raw : c_nop;
    end

    assign cmd_ready_o  = (r_state != ST_TWO) && !reset;
    assign insn_valid_o = (r_state != ST_EMPTY);
    assign w_push       = cmd_valid_i && cmd_ready_o;
    assign w_pop        = insn_valid_o && insn_ready_i;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state      <= ST_EMPTY;
            r_head_insn  <= 32'd0;
            r_head_err   <= 1'b0;
            r_tail_insn  <= 32'd0;
            r_tail_err   <= 1'b0;
            r_insn_count <= 32'd0;
            r_err_count  <= '0;
        end else begin
            case (r_state)
                ST_EMPTY: begin
                    if (w_push) begin
                        r_head_insn <= w_enc;
                        r_head_err  <= !w_ok;
                        r_state     <= ST_ONE;
                    end
                end
                ST_ONE: begin
                    if (w_push && w_pop) begin
                        r_head_insn <= w_enc;
                        r_head_err  <= !w_ok;
                    end else if (w_push) begin
                        r_tail_insn <= w_enc;
                        r_tail_err  <= !w_ok;
                        r_state     <= ST_TWO;
                    end else if (w_pop) begin
                        r_state     <= ST_EMPTY;
                    end
                end
                ST_TWO: begin
                    if (w_pop) begin
                        r_head_insn <= r_tail_insn;
                        r_head_err  <= r_tail_err;
                        r_state     <= ST_ONE;
                    end
                end
                default: r_state <= ST_EMPTY;
            endcase
            if (w_pop) begin
                r_insn_count <= r_insn_count + 32'd1;
                if (r_head_err && !(&r_err_count))
                    r_err_count <= r_err_count + 1'b1;
            end
        end
    end

    assign insn_o       = r_head_insn;
    assign err_o        = r_head_err;
    assign insn_count_o = r_insn_count;
    assign err_count_o  = r_err_count;

endmodule

`default_nettype wire

// File: tb/tb_insn_encoder.sv
// ============================================================================
// Module   : tb_insn_encoder
// Brief    : Scoreboard bench for insn_encoder with a field-level reference model.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_insn_encoder;

    localparam logic [6:0] OP_R = 7'h33, OP_I = 7'h13, OP_LD = 7'h03, OP_ST = 7'h23,
                           OP_BR = 7'h63, OP_JAL = 7'h6F, OP_JALR = 7'h67,
                           OP_LUI = 7'h37, OP_AUIPC = 7'h17;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic [6:0]  cmd_opcode = '0;
    logic [3:0]  cmd_alusel = '0;
    logic [2:0]  cmd_funct3 = '0;
    logic [4:0]  cmd_rd = '0, cmd_rs1 = '0, cmd_rs2 = '0;
    logic [31:0] cmd_imm = '0;
    logic        insn_valid;
    logic        insn_ready = 1'b0;
    logic [31:0] insn;
    logic        err;
    logic [31:0] insn_count;
    logic [15:0] err_count;

    int vectors = 0;
    int miscompares = 0;
    int n_acc = 0;
    logic [32:0] q[$];
    bit          use_forced = 0;
    logic [32:0] forced_exp = '0;

    insn_encoder #(.DWIDTH(32), .ERRCNT_W(16)) dut (
        .clk(clk), .reset(reset),
        .cmd_valid_i(cmd_valid), .cmd_ready_o(cmd_ready),
        .cmd_opcode_i(cmd_opcode), .cmd_alusel_i(cmd_alusel), .cmd_funct3_i(cmd_funct3),
        .cmd_rd_i(cmd_rd), .cmd_rs1_i(cmd_rs1), .cmd_rs2_i(cmd_rs2), .cmd_imm_i(cmd_imm),
        .insn_valid_o(insn_valid), .insn_ready_i(insn_ready),
        .insn_o(insn), .err_o(err),
        .insn_count_o(insn_count), .err_count_o(err_count)
    );

    always #5 clk = ~clk;

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        vectors++;
        if (act !== req) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
        end
    endtask

    // Reference model: computes {err, word} from the ISA field rules with integer arithmetic.
    function automatic logic [32:0] ref_enc(input logic [6:0] op, input logic [3:0] alu,
                                            input logic [2:0] f3, input logic [4:0] rd,
                                            input logic [4:0] rs1, input logic [4:0] rs2,
                                            input logic [31:0] imm);
        int s, af3, af7, bit_at;
        bit ok, shift;
        logic [31:0] w;
        s = $signed(imm);
        af7 = 0;
        shift = (alu == 2) || (alu == 6) || (alu == 7);
        case (alu)
            0: af3 = 0;  1: begin af3 = 0; af7 = 32; end
            2: af3 = 1;  3: af3 = 2;  4: af3 = 3;  5: af3 = 4;
            6: af3 = 5;  7: begin af3 = 5; af7 = 32; end
            8: af3 = 6;  9: af3 = 7;
            default: af3 = -1;
        endcase
        ok = 0;
        w = 0;
        case (op)
            OP_R: begin
                ok = (af3 >= 0);
                w = (32'(af7) << 25) | (32'(rs2) << 20) | (32'(rs1) << 15) | (32'(af3) << 12)
                  | (32'(rd) << 7) | 32'(op);
            end
            OP_I: begin
                if (shift) begin
                    ok = (imm < 32);
                    w = (32'(af7) << 25) | (imm << 20);
                end else begin
                    ok = (af3 >= 0) && (alu != 1) && (s >= -2048) && (s <= 2047);
                    w = (imm & 32'hFFF) << 20;
                end
                w = w | (32'(rs1) << 15) | (32'(af3 & 7) << 12) | (32'(rd) << 7) | 32'(op);
            end
            OP_LD, OP_JALR: begin
                ok = (s >= -2048) && (s <= 2047);
                if (op == OP_LD) ok = ok && (f3 inside {0, 1, 2, 4, 5});
                w = ((imm & 32'hFFF) << 20) | (32'(rs1) << 15)
                  | (32'(op == OP_LD ? f3 : 3'd0) << 12) | (32'(rd) << 7) | 32'(op);
            end
            OP_ST: begin
                ok = (s >= -2048) && (s <= 2047) && (f3 <= 2);
                w = (((imm >> 5) & 32'h7F) << 25) | (32'(rs2) << 20) | (32'(rs1) << 15)
                  | (32'(f3) << 12) | ((imm & 32'h1F) << 7) | 32'(op);
            end
            OP_BR: begin
                ok = (s >= -4096) && (s <= 4095) && (s % 2 == 0) && (f3 inside {0, 1, 4, 5, 6, 7});
                w = (32'(rs2) << 20) | (32'(rs1) << 15) | (32'(f3) << 12) | 32'(op);
                bit_at = (imm >> 12) & 1;       w = w | (32'(bit_at) << 31);
                w = w | (((imm >> 5) & 32'h3F) << 25);
                w = w | (((imm >> 1) & 32'hF) << 8);
                bit_at = (imm >> 11) & 1;       w = w | (32'(bit_at) << 7);
            end
            OP_JAL: begin
                ok = (s >= -1048576) && (s <= 1048575) && (s % 2 == 0);
                w = (32'(rd) << 7) | 32'(op);
                bit_at = (imm >> 20) & 1;       w = w | (32'(bit_at) << 31);
                w = w | (((imm >> 1) & 32'h3FF) << 21);
                bit_at = (imm >> 11) & 1;       w = w | (32'(bit_at) << 20);
                w = w | (((imm >> 12) & 32'hFF) << 12);
            end
            OP_LUI, OP_AUIPC: begin
                ok = (imm % 4096 == 0);
                w = imm | (32'(rd) << 7) | 32'(op);
            end
            default: ok = 0;
        endcase
        return ok ? {1'b0, w} : {1'b1, 32'h0000_0013};
    endfunction

    // Acceptor: records the expected word at every accepted handshake.
    always @(negedge clk) begin
        if (!reset && cmd_valid && cmd_ready) begin
            if (use_forced) q.push_back(forced_exp);
            else q.push_back(ref_enc(cmd_opcode, cmd_alusel, cmd_funct3, cmd_rd,
                                     cmd_rs1, cmd_rs2, cmd_imm));
            n_acc++;
        end
    end

    // Monitor: pops on each delivered word, tracks counters and stall stability.
    int          exp_icnt = 0, exp_ecnt = 0;
    bit          prev_stall = 0;
    logic [32:0] prev_word = '0;
    always @(negedge clk) begin
        logic [32:0] e;
        if (reset) begin
            q.delete();
            exp_icnt = 0;
            exp_ecnt = 0;
            prev_stall = 0;
        end else begin
            check("insn_count", insn_count, exp_icnt);
            check("err_count", err_count, exp_ecnt);
            if (prev_stall && insn_valid) check("stall_hold", {err, insn}, prev_word);
            if (insn_valid && insn_ready) begin
                if (q.size() == 0) begin
                    check("unexpected_word", {err, insn}, 33'h1_FFFF_FFFF);
                end else begin
                    e = q.pop_front();
                    check("insn_word", {err, insn}, e);
                    exp_icnt++;
                    if (e[32] && exp_ecnt < 65535) exp_ecnt++;
                end
            end
            prev_stall = insn_valid && !insn_ready;
            prev_word = {err, insn};
        end
    end

    task automatic set_fields(input logic [6:0] op, input logic [3:0] alu, input logic [2:0] f3,
                              input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2,
                              input logic [31:0] imm);
        cmd_opcode = op; cmd_alusel = alu; cmd_funct3 = f3;
        cmd_rd = rd; cmd_rs1 = rs1; cmd_rs2 = rs2; cmd_imm = imm;
    endtask

    task automatic wait_accept(input string name);
        bit done = 0;
        for (int i = 0; i < 50 && !done; i++) begin
            @(negedge clk);
            if (cmd_ready) done = 1;
            @(posedge clk); #1;
        end
        if (!done) check({name, "_accept_timeout"}, 0, 1);
        cmd_valid = 0;
        use_forced = 0;
    endtask

    task automatic send_forced(input string name, input logic [32:0] exp);
        forced_exp = exp;
        use_forced = 1;
        cmd_valid = 1;
        wait_accept(name);
    endtask

    task automatic drain(input string name);
        int n = 0;
        insn_ready = 1;
        while (q.size() != 0 && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        @(negedge clk);
        check({name, "_drained"}, q.size(), 0);
    endtask

    task automatic do_reset();
        @(posedge clk); #1;
        reset = 1;
        @(posedge clk); #1;
        reset = 0;
    endtask

    function automatic logic [31:0] rand_imm();
        int b[14] = '{2047, 2048, -2048, -2049, 4094, 4095, -4096, -4098,
                      1048574, 1048576, -1048576, -1048578, 31, 32};
        case ($urandom % 8)
            0: return $urandom;
            1: return 32'(int'($urandom_range(0, 8400)) - 4200);
            2: return 32'(b[$urandom % 14]);
            3: return $urandom & 32'hFFFF_F000;
            4: return 32'(int'($urandom_range(0, 2097151)) - 1048576);
            5: return 32'($urandom_range(0, 63));
            default: return 32'(int'($urandom_range(0, 4095)) - 2048);
        endcase
    endfunction

    task automatic rand_fields();
        logic [6:0] ops[9] = '{OP_R, OP_I, OP_LD, OP_ST, OP_BR, OP_JAL, OP_JALR, OP_LUI, OP_AUIPC};
        logic [6:0] op;
        if ($urandom % 10 == 0) op = 7'($urandom);
        else op = ops[$urandom % 9];
        set_fields(op, 4'($urandom_range(0, 11)), 3'($urandom), 5'($urandom),
                   5'($urandom), 5'($urandom), rand_imm());
    endtask

    initial begin
        int base;
        @(negedge clk);
        check("ready_in_reset", cmd_ready, 0);
        @(posedge clk); #1;
        reset = 0;
        @(negedge clk);
        check("reset_valid", insn_valid, 0);
        check("reset_insn", insn, 0);
        check("reset_err", err, 0);
        check("reset_ready", cmd_ready, 1);

        @(posedge clk); #1;
        insn_ready = 1;
        set_fields(OP_R, 4'd0, 3'd0, 5'd3, 5'd1, 5'd2, 32'd0);
        send_forced("r_add", {1'b0, 32'h0020_81B3});
        check("latency_valid", insn_valid, 1);
        set_fields(OP_R, 4'd1, 3'd0, 5'd5, 5'd6, 5'd7, 32'd0);
        send_forced("r_sub", {1'b0, 32'h4073_02B3});
        set_fields(OP_I, 4'd0, 3'd0, 5'd1, 5'd0, 5'd0, 32'hFFFF_FFFF);
        send_forced("i_addi", {1'b0, 32'hFFF0_0093});
        set_fields(OP_BR, 4'd0, 3'd0, 5'd0, 5'd1, 5'd2, 32'd8);
        send_forced("beq", {1'b0, 32'h0020_8463});
        set_fields(OP_JAL, 4'd0, 3'd0, 5'd1, 5'd0, 5'd0, 32'd2048);
        send_forced("jal", {1'b0, 32'h0010_00EF});
        drain("directed");

        do_reset();
        set_fields(OP_I, 4'd0, 3'd0, 5'd1, 5'd0, 5'd0, 32'd2048);
        send_forced("i_illegal", {1'b1, 32'h0000_0013});
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("illegal_err_count", err_count, 1);
        check("illegal_insn_count", insn_count, 1);

        // Backpressure: two fill the buffer, the third waits for space.
        @(posedge clk); #1;
        insn_ready = 0;
        base = n_acc;
        rand_fields();
        cmd_valid = 1;
        @(posedge clk); #1;
        rand_fields();
        @(posedge clk); #1;
        rand_fields();
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("bp_ready_low", cmd_ready, 0);
        check("bp_two_accepted", n_acc - base, 2);
        check("bp_valid", insn_valid, 1);
        @(posedge clk); #1;
        insn_ready = 1;
        wait_accept("bp_third");
        drain("bp");
        check("bp_three_accepted", n_acc - base, 3);

        // Reset while full.
        @(posedge clk); #1;
        insn_ready = 0;
        rand_fields(); cmd_valid = 1; wait_accept("fill1");
        rand_fields(); cmd_valid = 1; wait_accept("fill2");
        @(negedge clk);
        check("full_ready", cmd_ready, 0);
        do_reset();
        @(negedge clk);
        check("rst_mid_valid", insn_valid, 0);
        check("rst_mid_icnt", insn_count, 0);
        check("rst_mid_ecnt", err_count, 0);
        check("rst_mid_ready", cmd_ready, 1);

        @(posedge clk); #1;
        for (int i = 0; i < 3000; i++) begin
            rand_fields();
            cmd_valid  = ($urandom % 4) != 0;
            insn_ready = ($urandom % 4) != 0;
            @(posedge clk); #1;
        end
        cmd_valid = 0;
        drain("random");

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

`default_nettype wire
